// File: rtl/dmu_sii_tx.sv
// ---------------------------------------------------------------------------
// dmu_sii_tx
//
// DMU-side transmitter for the inbound DMU->SII interface. Whole packets from
// the DMU core (DMA read, DMA write, Mondo, PIO read return) are captured in
// one holding register on accept. Each packet is sent as a header cycle
// followed by 0, 1 or 4 payload beats, with even parity per 16-bit lane.
// DMA writes use one credit per tag. A 16-bit outstanding bitmap is set when
// a write is accepted and cleared when its write-ack returns.
//
// Handshake: a packet is accepted on any rising edge of iol2clk where
// req_vld & req_rdy. req_rdy is combinational. It depends on the current
// request (type and tag) and on registered state only, never on req_vld.
// After the accept edge the request inputs are not used again.
//
// Ports
//   iol2clk            clock
//   rst_l              asynchronous active-low reset
//   req_vld/req_rdy    packet handshake from the DMU core
//   req_type           0 DMA read, 1 DMA write, 2 Mondo, 3 PIO read return
//   req_bypass         bypass queue select (reads/writes only)
//   req_hdr            128-bit header; [79:64] tag ID, [39:0] PA
//   req_data           4 x 128-bit payload beats, beat n = [128n+127:128n]
//   req_be             4 x 16-bit write byte enables, beat n = [16n+15:16n]
//   sii_dmu_wrack_*    write credit return (valid + tag)
//   dmu_sii_*          registered header/payload stream towards SII
//   wr_outstanding     number of outstanding write tags
//   err_wrack          one-cycle pulse: write-ack for a tag not outstanding
//   fsm_state          debug view of the transmit FSM (0 idle, 1 hdr, 2 pay)
// ---------------------------------------------------------------------------
module dmu_sii_tx #(
    parameter int WR_CREDITS = 16
) (
    input  logic         iol2clk,
    input  logic         rst_l,

    input  logic         req_vld,
    output logic         req_rdy,
    input  logic [1:0]   req_type,
    input  logic         req_bypass,
    input  logic [127:0] req_hdr,
    input  logic [511:0] req_data,
    input  logic [63:0]  req_be,

    input  logic         sii_dmu_wrack_vld,
    input  logic [3:0]   sii_dmu_wrack_tag,

    output logic         dmu_sii_hdr_vld,
    output logic         dmu_sii_datareq,
    output logic         dmu_sii_datareq16,
    output logic         dmu_sii_reqbypass,
    output logic [127:0] dmu_sii_data,
    output logic [7:0]   dmu_sii_parity,
    output logic [15:0]  dmu_sii_be,

    output logic [4:0]   wr_outstanding,
    output logic         err_wrack,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    localparam logic [1:0] T_RD    = 2'd0;
    localparam logic [1:0] T_WR    = 2'd1;
    localparam logic [1:0] T_MONDO = 2'd2;
    localparam logic [1:0] T_PIO   = 2'd3;

    localparam logic [4:0] CREDIT_LIMIT = 5'(WR_CREDITS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state;
    logic [1:0]     bcnt;           // index of the payload beat on the bus
    logic [1:0]     hold_type;
    logic [511:0]   hold_data;
    logic [63:0]    hold_be;
    logic [15:0]    outstanding;    // one bit per write tag in flight

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] lane_parity(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i] = ^d[16*i +: 16];
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic           has_pay;
    logic [1:0]     last_beat;
    logic           slot_free;
    logic [3:0]     req_tag;
    logic           credit_ok;
    logic           accept;
    logic [1:0]     nxt_beat;
    logic [127:0]   beat_data;
    logic [15:0]    beat_be;
    logic           hdr_datareq;
    logic           hdr_datareq16;
    logic           hdr_bypass;

    always_comb begin
        has_pay   = (hold_type != T_RD);
        last_beat = (hold_type == T_WR) ? 2'd3 : 2'd0;

        // The output register can take a new header next cycle when nothing
        // of the held packet remains to be sent after the current cycle.
        slot_free = (state == ST_IDLE)
                 || ((state == ST_HDR) && !has_pay)
                 || ((state == ST_PAY) && (bcnt == last_beat));

        req_tag   = req_hdr[67:64];
        // Uses the registered bitmap, so a same-cycle wrack for this tag
        // only frees it from the following cycle on.
        credit_ok = !outstanding[req_tag] && (wr_outstanding < CREDIT_LIMIT);

        req_rdy   = rst_l && slot_free && ((req_type != T_WR) || credit_ok);
        accept    = req_vld && req_rdy;

        // Beat that goes on the bus at the next edge when staying in a packet.
        nxt_beat  = (state == ST_PAY) ? (bcnt + 2'd1) : 2'd0;
        beat_data = hold_data[{nxt_beat, 7'd0} +: 128];
        beat_be   = (hold_type == T_WR) ? hold_be[{nxt_beat, 4'd0} +: 16] : 16'd0;

        hdr_datareq   = (req_type != T_RD);
        hdr_datareq16 = req_type[1];
        case (req_type)
            T_MONDO: hdr_bypass = 1'b0;
            T_PIO:   hdr_bypass = 1'b1;
            default: hdr_bypass = req_bypass;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state             <= ST_IDLE;
            bcnt              <= 2'd0;
            hold_type         <= T_RD;
            hold_data         <= '0;
            hold_be           <= '0;
            dmu_sii_hdr_vld   <= 1'b0;
            dmu_sii_datareq   <= 1'b0;
            dmu_sii_datareq16 <= 1'b0;
            dmu_sii_reqbypass <= 1'b0;
            dmu_sii_data      <= '0;
            dmu_sii_parity    <= '0;
            dmu_sii_be        <= '0;
        end else begin
            // Idle cycles drive zeros; each branch below overrides as needed.
            dmu_sii_hdr_vld   <= 1'b0;
            dmu_sii_datareq   <= 1'b0;
            dmu_sii_datareq16 <= 1'b0;
            dmu_sii_reqbypass <= 1'b0;
            dmu_sii_data      <= '0;
            dmu_sii_parity    <= '0;
            dmu_sii_be        <= '0;

            // An accept only happens when the slot is free, which is exactly
            // when the current packet has nothing left to send, so a new
            // header always takes priority over the case logic below.
            if (accept) begin
                hold_type         <= req_type;
                hold_data         <= req_data;
                hold_be           <= req_be;
                dmu_sii_hdr_vld   <= 1'b1;
                dmu_sii_datareq   <= hdr_datareq;
                dmu_sii_datareq16 <= hdr_datareq16;
                dmu_sii_reqbypass <= hdr_bypass;
                dmu_sii_data      <= req_hdr;
                dmu_sii_parity    <= lane_parity(req_hdr);
                bcnt              <= 2'd0;
                state             <= ST_HDR;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_HDR: begin
                        if (has_pay) begin
                            dmu_sii_data   <= beat_data;
                            dmu_sii_parity <= lane_parity(beat_data);
                            dmu_sii_be     <= beat_be;
                            bcnt           <= 2'd0;
                            state          <= ST_PAY;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_PAY: begin
                        if (bcnt == last_beat) begin
                            bcnt  <= 2'd0;
                            state <= ST_IDLE;
                        end else begin
                            dmu_sii_data   <= beat_data;
                            dmu_sii_parity <= lane_parity(beat_data);
                            dmu_sii_be     <= beat_be;
                            bcnt           <= nxt_beat;
                            state          <= ST_PAY;
                        end
                    end
                    default: begin
                        bcnt  <= 2'd0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Write credit tracking
    // ------------------------------------------------------------------
    logic        wr_set;
    logic        wr_clr;
    logic        wrack_bad;
    logic [15:0] set_vec;
    logic [15:0] clr_vec;

    always_comb begin
        wr_set    = accept && (req_type == T_WR);
        wr_clr    = sii_dmu_wrack_vld && outstanding[sii_dmu_wrack_tag];
        wrack_bad = sii_dmu_wrack_vld && !outstanding[sii_dmu_wrack_tag];
        set_vec   = wr_set ? (16'd1 << req_tag) : 16'd0;
        clr_vec   = wr_clr ? (16'd1 << sii_dmu_wrack_tag) : 16'd0;
    end

    // Set and clear never hit the same tag (accept is gated by the
    // registered bitmap), so both can be applied in the same cycle.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            outstanding    <= '0;
            wr_outstanding <= '0;
            err_wrack      <= 1'b0;
        end else begin
            outstanding    <= (outstanding & ~clr_vec) | set_vec;
            wr_outstanding <= wr_outstanding + 5'(wr_set) - 5'(wr_clr);
            err_wrack      <= wrack_bad;
        end
    end

endmodule

// File: tb/tb_dmu_sii_tx.sv
// ---------------------------------------------------------------------------
// tb_dmu_sii_tx
//
// Directed then random stimulus for dmu_sii_tx. The reference model is a
// queue of expected bus cycles: an accepted packet expands into its header
// entry plus its payload entries, and one entry is popped per clock. The
// slot is free exactly when no entry is waiting behind the one on the bus.
// Write credits are modelled as a 16-bit set of tags in flight.
// ---------------------------------------------------------------------------
module tb_dmu_sii_tx;

    localparam int TB_CREDITS = 2;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic         iol2clk;
    logic         rst_l;
    logic         req_vld;
    logic         req_rdy;
    logic [1:0]   req_type;
    logic         req_bypass;
    logic [127:0] req_hdr;
    logic [511:0] req_data;
    logic [63:0]  req_be;
    logic         sii_dmu_wrack_vld;
    logic [3:0]   sii_dmu_wrack_tag;
    logic         dmu_sii_hdr_vld;
    logic         dmu_sii_datareq;
    logic         dmu_sii_datareq16;
    logic         dmu_sii_reqbypass;
    logic [127:0] dmu_sii_data;
    logic [7:0]   dmu_sii_parity;
    logic [15:0]  dmu_sii_be;
    logic [4:0]   wr_outstanding;
    logic         err_wrack;
    logic [1:0]   fsm_state;

    initial begin
        iol2clk = 1'b0;
        forever #5 iol2clk = ~iol2clk;
    end

    dmu_sii_tx #(.WR_CREDITS(TB_CREDITS)) dut (
        .iol2clk           (iol2clk),
        .rst_l             (rst_l),
        .req_vld           (req_vld),
        .req_rdy           (req_rdy),
        .req_type          (req_type),
        .req_bypass        (req_bypass),
        .req_hdr           (req_hdr),
        .req_data          (req_data),
        .req_be            (req_be),
        .sii_dmu_wrack_vld (sii_dmu_wrack_vld),
        .sii_dmu_wrack_tag (sii_dmu_wrack_tag),
        .dmu_sii_hdr_vld   (dmu_sii_hdr_vld),
        .dmu_sii_datareq   (dmu_sii_datareq),
        .dmu_sii_datareq16 (dmu_sii_datareq16),
        .dmu_sii_reqbypass (dmu_sii_reqbypass),
        .dmu_sii_data      (dmu_sii_data),
        .dmu_sii_parity    (dmu_sii_parity),
        .dmu_sii_be        (dmu_sii_be),
        .wr_outstanding    (wr_outstanding),
        .err_wrack         (err_wrack),
        .fsm_state         (fsm_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // Entry layout: {hdr_vld, datareq, datareq16, reqbypass, be[15:0], data}
    // ------------------------------------------------------------------
    logic [147:0] exp_q[$];
    logic [147:0] cur_exp;
    logic [15:0]  m_out;      // tags in flight
    logic         m_err;      // expected err_wrack after this edge
    bit           last_acc;
    int           n_total;
    int           n_pass;

    function automatic logic [7:0] ref_parity(input logic [127:0] d);
        logic [7:0]  p;
        logic [15:0] lane;
        for (int i = 0; i < 8; i++) begin
            lane = d[16*i +: 16];
            p[i] = ($countones(lane) % 2) == 1;
        end
        return p;
    endfunction

    function automatic bit model_rdy();
        logic [3:0] tag;
        tag = req_hdr[67:64];
        if (exp_q.size() != 0) return 1'b0;
        if (req_type != 2'd1) return 1'b1;
        return !m_out[tag] && ($countones(m_out) < TB_CREDITS);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_pkt(input logic [1:0] t, input logic byp, input logic [127:0] hdr,
                            input logic [511:0] d, input logic [63:0] be);
        logic f_dr, f_dr16, f_byp;
        int   nb;
        logic [15:0] bbe;
        case (t)
            2'd0:    begin f_dr = 0; f_dr16 = 0; f_byp = byp;  nb = 0; end
            2'd1:    begin f_dr = 1; f_dr16 = 0; f_byp = byp;  nb = 4; end
            2'd2:    begin f_dr = 1; f_dr16 = 1; f_byp = 1'b0; nb = 1; end
            default: begin f_dr = 1; f_dr16 = 1; f_byp = 1'b1; nb = 1; end
        endcase
        exp_q.push_back({1'b1, f_dr, f_dr16, f_byp, 16'd0, hdr});
        for (int n = 0; n < nb; n++) begin
            bbe = (t == 2'd1) ? be[16*n +: 16] : 16'd0;
            exp_q.push_back({4'b0000, bbe, d[128*n +: 128]});
        end
    endtask

    task automatic check_bus(input logic [147:0] e);
        check("hdr_vld",   128'(dmu_sii_hdr_vld),   128'(e[147]));
        check("datareq",   128'(dmu_sii_datareq),   128'(e[146]));
        check("datareq16", 128'(dmu_sii_datareq16), 128'(e[145]));
        check("reqbypass", 128'(dmu_sii_reqbypass), 128'(e[144]));
        check("be",        128'(dmu_sii_be),        128'(e[143:128]));
        check("data",      dmu_sii_data,            e[127:0]);
        check("parity",    128'(dmu_sii_parity),    128'(ref_parity(e[127:0])));
    endtask

    // One clock: check req_rdy before the edge, advance the model at the
    // edge, then check all registered outputs shortly after it.
    task automatic cycle();
        logic [3:0] wtag;
        #1;
        check("req_rdy", 128'(req_rdy), 128'(model_rdy()));
        @(posedge iol2clk);
        last_acc = req_vld && model_rdy();
        wtag     = sii_dmu_wrack_tag;
        m_err    = sii_dmu_wrack_vld && !m_out[wtag];
        if (sii_dmu_wrack_vld) m_out[wtag] = 1'b0;
        if (last_acc) begin
            push_pkt(req_type, req_bypass, req_hdr, req_data, req_be);
            if (req_type == 2'd1) m_out[req_hdr[67:64]] = 1'b1;
        end
        cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        #1;
        check_bus(cur_exp);
        check("wr_outstanding", 128'(wr_outstanding), 128'($countones(m_out)));
        check("err_wrack",      128'(err_wrack),      128'(m_err));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive_idle();
        req_vld           = 1'b0;
        req_type          = 2'd0;
        req_bypass        = 1'b0;
        req_hdr           = '0;
        req_data          = '0;
        req_be            = '0;
        sii_dmu_wrack_vld = 1'b0;
        sii_dmu_wrack_tag = 4'd0;
    endtask

    task automatic drive_req(input logic [1:0] t, input logic byp, input logic [127:0] hdr,
                             input logic [511:0] d, input logic [63:0] be);
        req_vld    = 1'b1;
        req_type   = t;
        req_bypass = byp;
        req_hdr    = hdr;
        req_data   = d;
        req_be     = be;
    endtask

    task automatic send(input logic [1:0] t, input logic byp, input logic [127:0] hdr,
                        input logic [511:0] d, input logic [63:0] be, input int budget);
        bit done;
        done = 1'b0;
        drive_req(t, byp, hdr, d, be);
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            done = last_acc;
        end
        req_vld = 1'b0;
        check("send_accepted", 128'(done), 128'(1));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [127:0] mk_hdr(input logic [15:0] tag, input logic [39:0] pa);
        logic [127:0] h;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[79:64] = tag;
        h[39:0]  = pa;
        return h;
    endfunction

    function automatic logic [511:0] rnd_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    logic [511:0] wdata;
    logic [127:0] h;

    initial begin
        n_total  = 0;
        n_pass   = 0;
        m_out    = '0;
        m_err    = 1'b0;
        last_acc = 1'b0;
        drive_idle();
        rst_l = 1'b0;

        // Reset state, with a request already presented.
        repeat (2) @(posedge iol2clk);
        drive_req(2'd0, 1'b1, 128'h1, '0, '0);
        #2;
        check("rst_req_rdy", 128'(req_rdy), 128'(0));
        check_bus('0);
        check("rst_wr_outstanding", 128'(wr_outstanding), 128'(0));
        check("rst_err_wrack", 128'(err_wrack), 128'(0));
        check("rst_fsm_state", 128'(fsm_state), 128'(0));
        drive_idle();
        @(negedge iol2clk);
        rst_l = 1'b1;

        // Back-to-back reads, first one from the test plan.
        h = 128'd0;
        h[79:64] = 16'h0012;
        h[39:0]  = 40'h12_3456_7880;
        send(2'd0, 1'b1, h, rnd_data(), '0, 4);
        send(2'd0, 1'b0, mk_hdr(16'h0013, 40'h1000), rnd_data(), '0, 4);
        send(2'd0, 1'b1, mk_hdr(16'h0014, 40'h2000), rnd_data(), '0, 4);
        drive_idle();
        idle_cycles(2);

        // Write tag 5, beats A0..A3, full byte enables.
        wdata = {128'hA3A3_A3A3_A3A3_A3A3_A3A3_A3A3_A3A3_A3A3,
                 128'hA2A2_A2A2_A2A2_A2A2_A2A2_A2A2_A2A2_A2A2,
                 128'hA1A1_A1A1_A1A1_A1A1_A1A1_A1A1_A1A1_A1A1,
                 128'hA0A0_A0A0_A0A0_A0A0_A0A0_A0A0_A0A0_A0A0};
        send(2'd1, 1'b1, mk_hdr(16'h0005, 40'h3000), wdata, {64{1'b1}}, 4);
        // Second write with tag 5 stalls behind the beats and then the tag.
        drive_req(2'd1, 1'b0, mk_hdr(16'h0005, 40'h3040), rnd_data(), 64'h0F0F_00FF_1234_FFFF);
        idle_cycles(6);
        check("tag5_stalled", 128'(req_rdy), 128'(0));
        check("tag5_count", 128'(wr_outstanding), 128'(1));
        sii_dmu_wrack_vld = 1'b1;
        sii_dmu_wrack_tag = 4'd5;
        cycle();
        sii_dmu_wrack_vld = 1'b0;
        cycle();
        check("tag5_reaccepted", 128'(last_acc), 128'(1));
        drive_idle();
        idle_cycles(5);

        // Mondo then PIO return, back-to-back.
        send(2'd2, 1'b1, mk_hdr(16'h0020, 40'h4000), rnd_data(), {64{1'b1}}, 4);
        send(2'd3, 1'b0, mk_hdr(16'h0021, 40'h5000), rnd_data(), {64{1'b1}}, 4);
        drive_idle();
        idle_cycles(2);

        // Free tag 5, then credit limit with tags 1, 2, 3.
        sii_dmu_wrack_vld = 1'b1;
        sii_dmu_wrack_tag = 4'd5;
        cycle();
        drive_idle();
        send(2'd1, 1'b0, mk_hdr(16'h0001, 40'h6000), rnd_data(), {$urandom, $urandom}, 8);
        send(2'd1, 1'b1, mk_hdr(16'h0002, 40'h6040), rnd_data(), {$urandom, $urandom}, 8);
        drive_req(2'd1, 1'b0, mk_hdr(16'h0003, 40'h6080), rnd_data(), {$urandom, $urandom});
        idle_cycles(6);
        check("credit_stall_rdy", 128'(req_rdy), 128'(0));
        check("credit_stall_count", 128'(wr_outstanding), 128'(2));
        sii_dmu_wrack_vld = 1'b1;
        sii_dmu_wrack_tag = 4'd1;
        cycle();
        sii_dmu_wrack_vld = 1'b0;
        cycle();
        check("credit_release", 128'(last_acc), 128'(1));
        drive_idle();
        idle_cycles(4);
        // Never-issued tag 9: error pulse, count unchanged.
        sii_dmu_wrack_vld = 1'b1;
        sii_dmu_wrack_tag = 4'd9;
        cycle();
        check("bad_wrack_err", 128'(err_wrack), 128'(1));
        sii_dmu_wrack_vld = 1'b0;
        cycle();
        check("bad_wrack_count", 128'(wr_outstanding), 128'(2));

        // Clear tags 2 and 3, then wrack tag 1 alongside write tag 4.
        sii_dmu_wrack_vld = 1'b1;
        sii_dmu_wrack_tag = 4'd2;
        cycle();
        sii_dmu_wrack_tag = 4'd3;
        cycle();
        drive_idle();
        send(2'd1, 1'b0, mk_hdr(16'h0001, 40'h7000), rnd_data(), {$urandom, $urandom}, 4);
        drive_idle();
        idle_cycles(4);
        sii_dmu_wrack_vld = 1'b1;
        sii_dmu_wrack_tag = 4'd1;
        send(2'd1, 1'b1, mk_hdr(16'h0004, 40'h7040), rnd_data(), {$urandom, $urandom}, 1);
        drive_idle();
        check("simul_count", 128'(wr_outstanding), 128'(1));
        idle_cycles(4);
        req_type = 2'd1;
        req_hdr  = mk_hdr(16'h0001, 40'h0);
        cycle();
        check("simul_tag1_free", 128'(req_rdy), 128'(1));
        req_hdr  = mk_hdr(16'h0004, 40'h0);
        cycle();
        check("simul_tag4_busy", 128'(req_rdy), 128'(0));
        drive_idle();

        // Reset during write beat 2.
        send(2'd1, 1'b0, mk_hdr(16'h0006, 40'h8000), rnd_data(), {$urandom, $urandom}, 4);
        drive_idle();
        idle_cycles(3);
        rst_l = 1'b0;
        #1;
        check_bus('0);
        check("midrst_count", 128'(wr_outstanding), 128'(0));
        check("midrst_req_rdy", 128'(req_rdy), 128'(0));
        exp_q.delete();
        m_out = '0;
        m_err = 1'b0;
        @(negedge iol2clk);
        rst_l = 1'b1;
        send(2'd0, 1'b0, mk_hdr(16'h0030, 40'h9000), rnd_data(), '0, 2);
        drive_idle();
        idle_cycles(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                drive_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          mk_hdr(16'($urandom_range(0, 15)), {8'($urandom), $urandom}),
                          rnd_data(), {$urandom, $urandom});
            end else begin
                req_vld = 1'b0;
            end
            sii_dmu_wrack_vld = ($urandom_range(0, 3) == 0);
            sii_dmu_wrack_tag = 4'($urandom_range(0, 15));
            cycle();
        end
        drive_idle();
        idle_cycles(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
